// File: rtl/pkt256_seg_tracker_pkg.sv
// pkt_rx_pkg: shared widths and word/context types for the 256b segment tracker (DATA_W, ID_W, SEG_W, NUM_ID, seg_word_t, id_ctx_t)
package pkt_rx_pkg;
  localparam int DATA_W = 256;
  localparam int ID_W = 4;
  localparam int SEG_W = 16;
  localparam int NUM_ID = 2 ** ID_W;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic [SEG_W-1:0]  segnum;
    logic              first;
    logic              late;
  } seg_word_t;
  typedef struct packed {
    logic             valid;
    logic [SEG_W-1:0] exp;
  } id_ctx_t;
endpackage

// File: rtl/pkt256_seg_tracker_sync_fifo.sv
// sync_fifo: show-ahead sync FIFO; ports clk/rst, wr_en/wr_data, rd_en/rd_data (zero when empty), full/empty; a read frees a full slot for a same-cycle write
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
endmodule

// File: rtl/pkt256_seg_tracker.sv
// pkt256_seg_tracker: per-id segment continuity tracker + show-ahead output FIFO; in: clk, RST, in256b/en_in/id_in/segnum_in, out_ready, stat_id; out: out_data/id/segnum/first/late/valid, gap_pulse, lost/late/ovf_total, stat_lost (per-id lost array only with SEG_TRACK_STATS_EN)
module pkt256_seg_tracker
  import pkt_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] in256b,
  input  logic              en_in,
  input  logic [ID_W-1:0]   id_in,
  input  logic [SEG_W-1:0]  segnum_in,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [SEG_W-1:0]  out_segnum,
  output logic              out_first,
  output logic              out_late,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              gap_pulse,
  output logic [CNT_W-1:0]  lost_total,
  output logic [CNT_W-1:0]  late_total,
  output logic [CNT_W-1:0]  ovf_total,
  input  logic [ID_W-1:0]   stat_id,
  output logic [CNT_W-1:0]  stat_lost
);
  id_ctx_t ctx [NUM_ID];
  id_ctx_t cur;
  seg_word_t s1, head;
  logic s1_v, have_last, late_seg, boundary, is_gap, is_late, late_word, full, empty, rd;
  logic [ID_W-1:0] last_id;
  logic [SEG_W-1:0] last_seg, d;
  logic [CNT_W:0] lost_sum;
  always_comb begin
    cur = ctx[id_in];
    boundary = en_in && (!have_last || id_in != last_id || segnum_in != last_seg);
    d = segnum_in - cur.exp;
    is_gap = boundary && cur.valid && d != '0 && !d[SEG_W-1];
    is_late = boundary && cur.valid && d[SEG_W-1];
    late_word = boundary ? is_late : late_seg;
  end
  assign lost_sum = {1'b0, lost_total} + (CNT_W+1)'(d);
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < NUM_ID; i++) ctx[i] <= '0;
      have_last <= 1'b0;
      last_id <= '0;
      last_seg <= '0;
      late_seg <= 1'b0;
      s1 <= '0;
      s1_v <= 1'b0;
      gap_pulse <= 1'b0;
      lost_total <= '0;
      late_total <= '0;
      ovf_total <= '0;
    end else begin
      if (boundary && !is_late) ctx[id_in] <= '{valid: 1'b1, exp: segnum_in + 1'b1};
      if (en_in) begin
        have_last <= 1'b1;
        last_id <= id_in;
        last_seg <= segnum_in;
        late_seg <= late_word;
      end
      s1 <= '{data: in256b, id: id_in, segnum: segnum_in, first: boundary, late: late_word};
      s1_v <= en_in;
      gap_pulse <= is_gap;
      if (is_gap) lost_total <= lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];
      if (is_late && late_total != '1) late_total <= late_total + 1'b1;
      if (s1_v && full && !rd && ovf_total != '1) ovf_total <= ovf_total + 1'b1;
    end
  end
  sync_fifo #(.W($bits(seg_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(RST),
    .wr_en(s1_v),
    .wr_data(s1),
    .rd_en(rd),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  assign out_valid = !empty;
  assign rd = out_valid && out_ready;
  assign out_data = head.data;
  assign out_id = head.id;
  assign out_segnum = head.segnum;
  assign out_first = head.first;
  assign out_late = head.late;
`ifdef SEG_TRACK_STATS_EN
  logic [CNT_W-1:0] lost [NUM_ID];
  logic [CNT_W:0] id_sum;
  assign id_sum = {1'b0, lost[id_in]} + (CNT_W+1)'(d);
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < NUM_ID; i++) lost[i] <= '0;
      stat_lost <= '0;
    end else begin
      if (is_gap) lost[id_in] <= id_sum[CNT_W] ? '1 : id_sum[CNT_W-1:0];
      stat_lost <= lost[stat_id];
    end
  end
`else
  logic unused_stat_id;
  assign unused_stat_id = ^stat_id;
  assign stat_lost = '0;
`endif
endmodule
